// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder slice.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  localparam int WORD_BYTES = 4;

  function automatic int index_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Synchronous single-port word array: write and registered read on the same edge.
module data_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  index,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[index] <= wdata;
    end
    rdata <= mem[index];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: valid/ready request in, wait states, registered response out.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // initiator holds its request (and fields) until it sees that edge, and the
  // responder holds resp_* stable until its own handshake edge.

  localparam int IDX_W = index_width(DEPTH);
  localparam int OFF_W = $clog2(WORD_BYTES);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  mem_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              wr_q, err_q, rdata_sel_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q, arr_rdata;
  logic              accept, do_access, resp_hs, req_err;
  logic [IDX_W-1:0]  req_idx;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign resp_hs   = resp_valid && resp_ready;
  assign req_idx   = req_addr[OFF_W +: IDX_W];
  assign req_err   = (req_addr[OFF_W-1:0] != '0) || ((req_addr >> (OFF_W + IDX_W)) != '0);

  // WAIT always runs WAIT_CYCLES+1 cycles (zero-count included), so the array
  // access and resp_valid land exactly WAIT_CYCLES+1 edges after acceptance.
  assign do_access = (state == WAIT) && (cnt == '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_W'(WAIT_CYCLES);
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      RESP: begin
        if (resp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      rdata_sel_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (do_access) begin
        resp_valid  <= 1'b1;
        resp_err    <= err_q;
        rdata_sel_q <= !wr_q && !err_q;
      end else if (resp_hs) begin
        resp_valid  <= 1'b0;
        resp_err    <= 1'b0;
        rdata_sel_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= req_write;
      err_q   <= req_err;
      idx_q   <= req_idx;
      wdata_q <= req_wdata;
    end
  end

  // idx_q is frozen through RESP and nothing writes there, so the array's
  // read register keeps returning the captured word until the handshake.
  data_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (do_access && wr_q && !err_q),
    .index (idx_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  assign resp_rdata = rdata_sel_q ? arr_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three builds (WAIT_CYCLES 2, 0 and 5) sharing clock and reset.
module tb_data_mem_responder;

  logic        clk, rst;
  logic [2:0]  req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr [3];
  logic [31:0] req_wdata [3];
  logic [31:0] resp_rdata [3];
  logic [2:0]  tie_ready;

  logic [32:0] exp_q[$];
  logic [31:0] model [64];
  int total, bad;

  data_mem_responder #(.WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  data_mem_responder #(.WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  data_mem_responder #(.WAIT_CYCLES(5)) u_dut_w5 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input int d);
    return (d == 0) ? 3 : (d == 1) ? 1 : 6;
  endfunction

  // driver + scoreboard: one full transaction on build d
  task automatic do_txn(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int hold, input logic poke);
    int guard;
    int lat;
    logic [31:0] held;
    logic [32:0] e;
    exp_q.push_back({exp_err, exp_rdata});
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_valid[d] = 1'b1;
    guard = 0;
    while (!req_ready[d] && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) chk("accept_timeout", 32'(guard), 32'd0);
    @(posedge clk); #1;
    if (poke) begin
      // a competing store held during the wait must not be taken
      req_write[d] = 1'b1;
      req_addr[d]  = 32'h0;
      req_wdata[d] = 32'hBAD0BAD0;
    end else begin
      req_valid[d] = 1'b0;
    end
    lat = 0;
    while (!resp_valid[d] && lat < 50) begin
      chk("busy_ready", {31'd0, req_ready[d]}, 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat(d)));
    held = resp_rdata[d];
    for (int i = 0; i < hold; i++) begin
      chk("bp_valid", {31'd0, resp_valid[d]}, 32'd1);
      chk("bp_rdata", resp_rdata[d], held);
      chk("bp_ready", {31'd0, req_ready[d]}, 32'd0);
      @(posedge clk); #1;
    end
    resp_ready[d] = 1'b1;
    e = exp_q.pop_front();
    chk("resp_valid", {31'd0, resp_valid[d]}, 32'd1);
    chk("resp_rdata", resp_rdata[d], e[31:0]);
    chk("resp_err", {31'd0, resp_err[d]}, {31'd0, e[32]});
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    if (!tie_ready[d]) resp_ready[d] = 1'b0;
    chk("post_valid", {31'd0, resp_valid[d]}, 32'd0);
    chk("post_rdata", resp_rdata[d], 32'd0);
    chk("post_err", {31'd0, resp_err[d]}, 32'd0);
    chk("post_ready", {31'd0, req_ready[d]}, 32'd1);
  endtask

  initial begin
    int idx;
    logic [31:0] val;
    total = 0;
    bad = 0;
    rst = 1'b1;
    req_valid = '0;
    req_write = '0;
    tie_ready = 3'b010;
    resp_ready = 3'b010;
    for (int i = 0; i < 3; i++) begin
      req_addr[i]  = '0;
      req_wdata[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_req_ready", {31'd0, req_ready[i]}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid[i]}, 32'd0);
      chk("rst_resp_rdata", resp_rdata[i], 32'd0);
      chk("rst_resp_err", {31'd0, resp_err[i]}, 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // default build: basic store/load, errors, backpressure
    do_txn(0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 0, 1'b0);
    do_txn(0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 0, 1'b0);
    do_txn(0, 1'b1, 32'h00,  32'h11111111, 32'h0,        1'b0, 0, 1'b0);
    do_txn(0, 1'b0, 32'h12,  32'h0,        32'h0,        1'b1, 0, 1'b0);
    do_txn(0, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1, 0, 1'b0);
    do_txn(0, 1'b1, 32'h102, 32'hFFFFFFFF, 32'h0,        1'b1, 0, 1'b0);
    do_txn(0, 1'b0, 32'h00,  32'h0,        32'h11111111, 1'b0, 0, 1'b0);
    do_txn(0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 5, 1'b0);

    for (int i = 0; i < 64; i++) model[i] = 32'h0;
    for (int i = 0; i < 6; i++) begin
      idx = $urandom_range(0, 63);
      val = $urandom;
      model[idx] = val;
      do_txn(0, 1'b1, 32'(idx) << 2, val, 32'h0, 1'b0, $urandom_range(0, 2), 1'b0);
      do_txn(0, 1'b0, 32'(idx) << 2, 32'h0, model[idx], 1'b0, $urandom_range(0, 2), 1'b0);
    end

    // reset during WAIT drops the pending store
    do_txn(0, 1'b1, 32'h20, 32'hAAAA5555, 32'h0, 1'b0, 0, 1'b0);
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h20;
    req_wdata[0] = 32'h12345678;
    req_valid[0] = 1'b1;
    chk("rst_test_ready", {31'd0, req_ready[0]}, 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_req_ready", {31'd0, req_ready[0]}, 32'd0);
    chk("midrst_resp_valid", {31'd0, resp_valid[0]}, 32'd0);
    @(posedge clk); #1;
    chk("midrst_req_ready2", {31'd0, req_ready[0]}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_resp", {31'd0, resp_valid[0]}, 32'd0);
    end
    do_txn(0, 1'b0, 32'h20, 32'h0, 32'hAAAA5555, 1'b0, 0, 1'b0);

    // zero-wait build, resp_ready tied high
    do_txn(1, 1'b1, 32'h04, 32'h1, 32'h0, 1'b0, 0, 1'b0);
    do_txn(1, 1'b0, 32'h04, 32'h0, 32'h1, 1'b0, 0, 1'b0);
    do_txn(1, 1'b0, 32'h03, 32'h0, 32'h0, 1'b1, 0, 1'b0);

    // five-wait build, a request held during WAIT is not taken
    do_txn(2, 1'b1, 32'h00, 32'h55, 32'h0,  1'b0, 0, 1'b0);
    do_txn(2, 1'b0, 32'h00, 32'h0,  32'h55, 1'b0, 2, 1'b1);
    do_txn(2, 1'b0, 32'h00, 32'h0,  32'h55, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
